alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_if.sv | 34 +++
 rtl/alu_pipe.sv | 198 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// alu_pipe_if -- operation/result bundle for alu_pipe.
//
// Signals:
//   in_valid, operand1, operand2, opcode : operation offered by the master
//   in_ready                             : block can take an operation this cycle
//   out, zero, ovf, div_err              : registered result and flags, held until the next result
//   out_valid                            : one-cycle pulse marking a new result
//
// Modports: master drives operations and observes results; slave is the ALU side.

interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             zero;
    logic             ovf;
    logic             div_err;

    modport master (
        output in_valid, operand1, operand2, opcode,
        input  in_ready, out, out_valid, zero, ovf, div_err
    );

    modport slave (
        input  in_valid, operand1, operand2, opcode,
        output in_ready, out, out_valid, zero, ovf, div_err
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe -- registered ALU with an iterative restoring divider.
//
// Ports:
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-low reset
//   bus        : alu_pipe_if.slave (operation in, result out)
//   dbg_state  : current FSM state (IDLE / DIV_RUN)
//
// Handshake: an operation is taken on a rising edge where in_valid && in_ready.
// in_valid may be raised independently of in_ready; when in_ready is low the
// offered inputs are simply ignored. out_valid is a one-cycle pulse and the
// result/flags stay put until the next pulse.
//
// ADD/SUB/MULT/logic/reserved ops and divide-by-zero finish on the accepting
// edge (result visible the next cycle). A DIV with a non-zero divisor moves
// to DIV_RUN and produces one quotient bit per cycle; the last bit is produced
// WIDTH edges after acceptance, on the same edge that writes out and returns
// to IDLE.

module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus,
    output logic [0:0] dbg_state
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] DIV_RUN = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;       // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] rem;       // partial remainder, always < divisor
    logic [WIDTH-1:0] dvs;       // divisor magnitude
    logic             neg_q;     // quotient must be negated at the end

    logic             accept;

    // Operands extended to 2*WIDTH so sums, differences and products are exact.
    logic [W2-1:0]    ext1;
    logic [W2-1:0]    ext2;
    logic [W2-1:0]    sum_x;
    logic [W2-1:0]    diff_x;
    logic [W2-1:0]    prod_x;

    logic [WIDTH-1:0] fast_out;
    logic             fast_ovf;
    logic             fast_err;

    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             take;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_quo;
    logic [WIDTH-1:0] q_final;
    logic             q_ovf;

    // Exact result does not fit WIDTH bits. Signed: the top WIDTH+1 bits must
    // all equal the result sign. Unsigned: everything above WIDTH must be zero
    // (this also catches a SUB borrow, which shows up as all-ones above WIDTH).
    function automatic logic overflow(input logic [W2-1:0] x);
        logic [WIDTH:0]   hi_s;
        logic [WIDTH-1:0] hi_u;
        hi_s = x[W2-1:WIDTH-1];
        hi_u = x[W2-1:WIDTH];
        if (SIGNED) begin
            return !((hi_s == '0) || (hi_s == '1));
        end
        return hi_u != '0;
    endfunction

    assign bus.in_ready = rst && (state == IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign dbg_state    = state;

    always_comb begin
        ext1   = {{WIDTH{SIGNED & bus.operand1[WIDTH-1]}}, bus.operand1};
        ext2   = {{WIDTH{SIGNED & bus.operand2[WIDTH-1]}}, bus.operand2};
        sum_x  = ext1 + ext2;
        diff_x = ext1 - ext2;
        prod_x = ext1 * ext2;
    end

    // Single-cycle result path. OP_DIV here only covers the divide-by-zero case;
    // non-zero divisors go to the iterative divider instead.
    always_comb begin
        fast_out = '0;
        fast_ovf = 1'b0;
        fast_err = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                fast_out = sum_x[WIDTH-1:0];
                fast_ovf = overflow(sum_x);
            end
            OP_SUB: begin
                fast_out = diff_x[WIDTH-1:0];
                fast_ovf = overflow(diff_x);
            end
            OP_MULT: begin
                fast_out = prod_x[WIDTH-1:0];
                fast_ovf = overflow(prod_x);
            end
            OP_DIV:  fast_err = 1'b1;
            OP_AND:  fast_out = bus.operand1 & bus.operand2;
            OP_OR:   fast_out = bus.operand1 | bus.operand2;
            OP_XOR:  fast_out = bus.operand1 ^ bus.operand2;
            default: fast_out = '0;
        endcase
    end

    // Magnitudes for the divider. The most-negative value maps to 2^(WIDTH-1),
    // which still fits as an unsigned WIDTH-bit number.
    always_comb begin
        mag1 = (SIGNED && bus.operand1[WIDTH-1]) ? (~bus.operand1 + ONE) : bus.operand1;
        mag2 = (SIGNED && bus.operand2[WIDTH-1]) ? (~bus.operand2 + ONE) : bus.operand2;
    end

    // One restoring-division step: shift in the next dividend bit, try to
    // subtract the divisor, keep the difference only if it is non-negative.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
        take     = !trial[WIDTH];
        next_rem = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        next_quo = {quo[WIDTH-2:0], take};
        q_final  = neg_q ? (~next_quo + ONE) : next_quo;
        // Only most-negative / -1 yields a positive magnitude of 2^(WIDTH-1).
        q_ovf    = SIGNED && !neg_q && next_quo[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            count         <= '0;
            quo           <= '0;
            rem           <= '0;
            dvs           <= '0;
            neg_q         <= 1'b0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.zero      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.div_err   <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if ((bus.opcode == OP_DIV) && (bus.operand2 != '0)) begin
                        state <= DIV_RUN;
                        count <= CW'(WIDTH);
                        quo   <= mag1;
                        rem   <= '0;
                        dvs   <= mag2;
                        neg_q <= SIGNED & (bus.operand1[WIDTH-1] ^ bus.operand2[WIDTH-1]);
                    end else begin
                        bus.out       <= fast_out;
                        bus.zero      <= (fast_out == '0);
                        bus.ovf       <= fast_ovf;
                        bus.div_err   <= fast_err;
                        bus.out_valid <= 1'b1;
                    end
                end
            end else begin
                quo   <= next_quo;
                rem   <= next_rem;
                count <= count - CW'(1);
                if (count == CW'(1)) begin
                    state         <= IDLE;
                    bus.out       <= q_final;
                    bus.zero      <= (q_final == '0);
                    bus.ovf       <= q_ovf;
                    bus.div_err   <= 1'b0;
                    bus.out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- checks alu_pipe at WIDTH=8 with one signed and one unsigned
// instance: reset behaviour, a vector table, multi-cycle DIV sequences, a
// reset abort and a random mix scored against an arithmetic model.

module tb_alu_pipe;

    localparam int W      = 8;
    localparam int EW     = W + 3;
    localparam int DL     = W + 1;
    localparam int N_RAND = 1000;

    logic       clk;
    logic       rst;
    logic [0:0] s_state;
    logic [0:0] u_state;

    alu_pipe_if #(.WIDTH(W)) s_if ();
    alu_pipe_if #(.WIDTH(W)) u_if ();

    alu_pipe #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
        .clk       (clk),
        .rst       (rst),
        .bus       (s_if),
        .dbg_state (s_state)
    );

    alu_pipe #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
        .clk       (clk),
        .rst       (rst),
        .bus       (u_if),
        .dbg_state (u_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit sb_on = 1'b0;

    logic [EW-1:0] exp_s_q[$];
    logic [EW-1:0] exp_u_q[$];

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [EW-1:0] exp;
        int           lat;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] pk(input bit e, input bit v, input bit z, input logic [W-1:0] o);
        return {e, v, z, o};
    endfunction

    function automatic logic [EW-1:0] s_act();
        return {s_if.div_err, s_if.ovf, s_if.zero, s_if.out};
    endfunction

    function automatic logic [EW-1:0] u_act();
        return {u_if.div_err, u_if.ovf, u_if.zero, u_if.out};
    endfunction

    // Arithmetic reference: exact integer result, wrapped to W bits, overflow
    // when the exact value falls outside the representable range.
    function automatic logic [EW-1:0] model(input bit sgn, input logic [2:0] op,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        longint x, y, r, lo, hi;
        logic [W-1:0] o;
        bit v, e;
        x  = sgn ? longint'($signed(a)) : longint'(a);
        y  = sgn ? longint'($signed(b)) : longint'(b);
        lo = sgn ? -(longint'(1) <<< (W - 1)) : longint'(0);
        hi = sgn ? (longint'(1) <<< (W - 1)) - 1 : (longint'(1) <<< W) - 1;
        r = 0; v = 1'b0; e = 1'b0; o = '0;
        case (op)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = x * y;
            3'd3: if (y == 0) e = 1'b1; else r = x / y;
            default: r = 0;
        endcase
        case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                o = r[W-1:0];
                v = !e && ((r < lo) || (r > hi));
            end
            3'd4: o = a & b;
            3'd5: o = a | b;
            3'd6: o = a ^ b;
            default: o = '0;
        endcase
        return {e, v, (o == '0), o};
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'(1);
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            4: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // driver: one operation on the signed instance, result and latency checked
    task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [EW-1:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        for (int i = 0; i < 40 && !s_if.in_ready; i++) @(negedge clk);
        s_if.opcode   = op;
        s_if.operand1 = a;
        s_if.operand2 = b;
        s_if.in_valid = 1'b1;
        @(negedge clk);
        s_if.in_valid = 1'b0;
        lat = 1;
        while (!s_if.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, " result"}, 32'(s_act()), 32'(exp));
        check({name, " latency"}, lat, exp_lat);
    endtask

    // scoreboard: every out_valid during the random phase pops one expectation
    always @(negedge clk) begin
        if (sb_on && rst && s_if.out_valid) begin
            if (exp_s_q.size() == 0) check("signed unexpected out_valid", 1, 0);
            else check("signed random result", 32'(s_act()), 32'(exp_s_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (sb_on && rst && u_if.out_valid) begin
            if (exp_u_q.size() == 0) check("unsigned unexpected out_valid", 1, 0);
            else check("unsigned random result", 32'(u_act()), 32'(exp_u_q.pop_front()));
        end
    end

    initial begin
        int lat, low_cnt, pulses, acc_s, acc_u, cyc;
        logic [2:0]   op;
        logic [W-1:0] a, b;

        tbl[0]  = '{3'd0, 8'h64, 8'h32, pk(0, 1, 0, 8'h96), 1};
        tbl[1]  = '{3'd2, 8'h0C, 8'hFD, pk(0, 0, 0, 8'hDC), 1};
        tbl[2]  = '{3'd1, 8'h05, 8'h05, pk(0, 0, 1, 8'h00), 1};
        tbl[3]  = '{3'd3, 8'h9C, 8'h07, pk(0, 0, 0, 8'hF2), DL};
        tbl[4]  = '{3'd3, 8'h05, 8'h00, pk(1, 0, 1, 8'h00), 1};
        tbl[5]  = '{3'd3, 8'h80, 8'hFF, pk(0, 1, 0, 8'h80), DL};
        tbl[6]  = '{3'd4, 8'hF0, 8'h3C, pk(0, 0, 0, 8'h30), 1};
        tbl[7]  = '{3'd5, 8'hF0, 8'h0C, pk(0, 0, 0, 8'hFC), 1};
        tbl[8]  = '{3'd6, 8'hFF, 8'hFF, pk(0, 0, 1, 8'h00), 1};
        tbl[9]  = '{3'd7, 8'h12, 8'h34, pk(0, 0, 1, 8'h00), 1};
        tbl[10] = '{3'd1, 8'h80, 8'h01, pk(0, 1, 0, 8'h7F), 1};
        tbl[11] = '{3'd0, 8'hFF, 8'h01, pk(0, 0, 1, 8'h00), 1};
        tbl[12] = '{3'd2, 8'h80, 8'hFF, pk(0, 1, 0, 8'h80), 1};
        tbl[13] = '{3'd3, 8'h7F, 8'hFE, pk(0, 0, 0, 8'hC1), DL};
        tbl[14] = '{3'd3, 8'h07, 8'h9C, pk(0, 0, 1, 8'h00), DL};
        tbl[15] = '{3'd2, 8'h10, 8'h10, pk(0, 1, 1, 8'h00), 1};

        s_if.in_valid = 1'b0; s_if.opcode = '0; s_if.operand1 = '0; s_if.operand2 = '0;
        u_if.in_valid = 1'b0; u_if.opcode = '0; u_if.operand1 = '0; u_if.operand2 = '0;

        // reset: outputs cleared asynchronously, in_ready low while held
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("reset signed", 32'({s_if.in_ready, s_if.out_valid, s_act()}), 0);
        check("reset unsigned", 32'({u_if.in_ready, u_if.out_valid, u_act()}), 0);
        repeat (3) @(negedge clk);
        check("reset held", 32'({s_if.in_ready, s_if.out_valid, s_act()}), 0);

        // first acceptance on the first rising edge with reset released
        s_if.opcode = 3'd0; s_if.operand1 = 8'd3; s_if.operand2 = 8'd4; s_if.in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        s_if.in_valid = 1'b0;
        check("first accept", 32'({s_if.out_valid, s_act()}), 32'({1'b1, pk(0, 0, 0, 8'd7)}));

        // vector table
        for (int i = 0; i < 16; i++)
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

        // MULT then SUB on consecutive edges: two consecutive out_valid pulses
        @(negedge clk);
        s_if.opcode = 3'd2; s_if.operand1 = 8'h0C; s_if.operand2 = 8'hFD; s_if.in_valid = 1'b1;
        @(negedge clk);
        check("b2b mult", 32'({s_if.out_valid, s_act()}), 32'({1'b1, pk(0, 0, 0, 8'hDC)}));
        s_if.opcode = 3'd1; s_if.operand1 = 8'h05; s_if.operand2 = 8'h05;
        @(negedge clk);
        s_if.in_valid = 1'b0;
        check("b2b sub", 32'({s_if.out_valid, s_act()}), 32'({1'b1, pk(0, 0, 1, 8'h00)}));
        @(negedge clk);
        check("b2b idle hold", 32'({s_if.out_valid, s_act()}), 32'({1'b0, pk(0, 0, 1, 8'h00)}));

        // DIV -100/7 with in_valid pulses and changing operands while it runs
        s_if.opcode = 3'd3; s_if.operand1 = 8'h9C; s_if.operand2 = 8'h07; s_if.in_valid = 1'b1;
        @(negedge clk);
        lat = 1; low_cnt = 0;
        while (!s_if.out_valid && lat < 40) begin
            if (!s_if.in_ready) low_cnt++;
            s_if.in_valid = (lat % 2 == 1);
            s_if.opcode   = 3'($urandom_range(0, 7));
            s_if.operand1 = W'($urandom);
            s_if.operand2 = W'($urandom_range(0, 3));
            @(negedge clk);
            lat++;
        end
        s_if.in_valid = 1'b0;
        check("div run result", 32'(s_act()), 32'(pk(0, 0, 0, 8'hF2)));
        check("div run latency", lat, DL);
        check("div ready low cycles", low_cnt, W);
        check("div ready back", 32'(s_if.in_ready), 1);
        @(negedge clk);
        check("div no extra result", 32'({s_if.out_valid, s_act()}), 32'({1'b0, pk(0, 0, 0, 8'hF2)}));

        // reset three cycles into DIV 77/3 aborts it
        do_op("pre abort add", 3'd0, 8'd1, 8'd2, pk(0, 0, 0, 8'd3), 1);
        @(negedge clk);
        s_if.opcode = 3'd3; s_if.operand1 = 8'd77; s_if.operand2 = 8'd3; s_if.in_valid = 1'b1;
        @(negedge clk);
        s_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort async clear", 32'({s_if.in_ready, s_if.out_valid, s_act()}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (s_if.out_valid) pulses++;
        end
        check("abort no out_valid", pulses, 0);
        do_op("post abort add", 3'd0, 8'd1, 8'd1, pk(0, 0, 0, 8'd2), 1);

        // random mix on both instances
        @(negedge clk);
        sb_on = 1'b1;
        acc_s = 0; acc_u = 0; cyc = 0;
        while ((acc_s < N_RAND || acc_u < N_RAND) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (acc_s < N_RAND && $urandom_range(0, 3) != 0) begin
                op = 3'($urandom_range(0, 7)); a = rnd_val(); b = rnd_val();
                s_if.opcode = op; s_if.operand1 = a; s_if.operand2 = b; s_if.in_valid = 1'b1;
                if (s_if.in_ready) begin
                    exp_s_q.push_back(model(1'b1, op, a, b));
                    acc_s++;
                end
            end else begin
                s_if.in_valid = 1'b0;
                s_if.operand1 = W'($urandom);
            end
            if (acc_u < N_RAND && $urandom_range(0, 3) != 0) begin
                op = 3'($urandom_range(0, 7)); a = rnd_val(); b = rnd_val();
                u_if.opcode = op; u_if.operand1 = a; u_if.operand2 = b; u_if.in_valid = 1'b1;
                if (u_if.in_ready) begin
                    exp_u_q.push_back(model(1'b0, op, a, b));
                    acc_u++;
                end
            end else begin
                u_if.in_valid = 1'b0;
                u_if.operand1 = W'($urandom);
            end
        end
        @(negedge clk);
        s_if.in_valid = 1'b0;
        u_if.in_valid = 1'b0;
        for (int i = 0; i < 40 && (exp_s_q.size() != 0 || exp_u_q.size() != 0); i++) @(negedge clk);
        check("random signed accepted", acc_s, N_RAND);
        check("random unsigned accepted", acc_u, N_RAND);
        check("random signed drained", exp_s_q.size(), 0);
        check("random unsigned drained", exp_u_q.size(), 0);
        sb_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
